// File: rtl/global_bht_update_ctrl_pkg.sv
// Shared types for the gshare global BHT control stage.
package global_bht_update_ctrl_pkg;

    localparam int BHT_LINE_W = 128;

    typedef logic [15:0]             lc3b_word;
    typedef logic [14:0]             lc3b_ghr;
    typedef logic [5:0]              lc3b_bht_offset;
    typedef logic [11:0]             lc3b_global_bht_pattern_index;
    typedef logic [BHT_LINE_W-1:0]   lc3b_bht_line;

    typedef struct packed {
        lc3b_global_bht_pattern_index index;
        lc3b_bht_offset               offset;
        logic                         taken;
    } lc3b_bht_update_req;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } lc3b_bht_upd_state;

    // 2-bit saturating counter step: 00 SNT, 01 WNT, 10 WT, 11 ST.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/global_bht_update_ctrl_fifo.sv
// Resolution buffer: DEPTH entries, registered write, combinational head read.
// A push while full is accepted only if the same cycle pops; a pop while empty is ignored.
module bht_update_fifo
    import global_bht_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  lc3b_bht_update_req push_data,
    input  logic               pop,
    output lc3b_bht_update_req pop_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    lc3b_bht_update_req entries [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               wr_en;
    logic               rd_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign pop_data = entries[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) entries[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/global_bht_update_ctrl.sv
// Gshare predict hash + GHR, and a 3-cycle read-modify-write retire path for resolved branches.
// Resolutions are buffered; resolve_ready drops only while the buffer is full.
module global_bht_update_ctrl
    import global_bht_update_ctrl_pkg::*;
#(
    parameter int GHR_LEN    = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         predict_valid,
    input  lc3b_word                     fetch_pc,
    output logic                         pred_taken,
    output lc3b_global_bht_pattern_index pred_index,
    output lc3b_bht_offset               pred_offset,
    output logic [GHR_LEN-1:0]           pred_ghr,
    input  logic                         resolve_valid,
    output logic                         resolve_ready,
    input  logic                         resolve_taken,
    input  logic                         resolve_mispred,
    input  lc3b_global_bht_pattern_index resolve_index,
    input  lc3b_bht_offset               resolve_offset,
    input  logic [GHR_LEN-1:0]           resolve_ghr,
    output lc3b_global_bht_pattern_index bht_index,
    input  lc3b_bht_line                 bht_rdata,
    output lc3b_global_bht_pattern_index bht_index_in,
    input  lc3b_bht_line                 bht_dataout,
    output logic                         bht_write,
    output lc3b_bht_line                 bht_datain
);

    logic [GHR_LEN-1:0] ghr;
    logic [1:0]         pred_ctr;
    logic               resolve_fire;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    lc3b_bht_update_req fifo_head;
    lc3b_bht_update_req push_req;
    lc3b_bht_upd_state  state;
    lc3b_bht_upd_state  state_nxt;
    lc3b_bht_update_req req;
    lc3b_bht_line       line_q;
    lc3b_bht_line       upd_line;
    logic               unused_bits;

    assign pred_index  = fetch_pc[12:1] ^ ghr[11:0];
    assign pred_offset = {fetch_pc[15:13], ghr[GHR_LEN-1 -: 3]};
    assign pred_ctr    = bht_rdata[{pred_offset, 1'b0} +: 2];
    assign pred_taken  = pred_ctr[1];
    assign pred_ghr    = ghr;
    assign bht_index   = pred_index;

    // Bits that fall off the history shift or below the halfword-aligned PC.
    assign unused_bits = resolve_ghr[GHR_LEN-1] ^ fetch_pc[0];

    assign resolve_ready = !fifo_full;
    assign resolve_fire  = resolve_valid && resolve_ready;

    // A mispredict restores the checkpoint and overrides any speculative shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr <= '0;
        end else if (resolve_fire && resolve_mispred) begin
            ghr <= {resolve_ghr[GHR_LEN-2:0], resolve_taken};
        end else if (predict_valid) begin
            ghr <= {ghr[GHR_LEN-2:0], pred_taken};
        end
    end

    assign push_req = '{index: resolve_index, offset: resolve_offset, taken: resolve_taken};

    bht_update_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (resolve_fire),
        .push_data (push_req),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        upd_line = bht_dataout;
        upd_line[{req.offset, 1'b0} +: 2] = sat_update(bht_dataout[{req.offset, 1'b0} +: 2], req.taken);
    end

    always_comb begin
        state_nxt    = state;
        fifo_pop     = 1'b0;
        bht_write    = 1'b0;
        bht_index_in = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                bht_index_in = req.index;
                state_nxt    = WRITE;
            end
            WRITE: begin
                bht_write    = 1'b1;
                bht_index_in = req.index;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            req    <= '0;
            line_q <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_pop) req <= fifo_head;
            if (state == READ) line_q <= upd_line;
        end
    end

    assign bht_datain = line_q;

endmodule

// File: tb/tb_global_bht_update_ctrl.sv
// Directed bench for global_bht_update_ctrl with a behavioural pattern array (negedge commit).
module tb_global_bht_update_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         predict_valid;
    logic [15:0]  fetch_pc;
    logic         pred_taken;
    logic [11:0]  pred_index;
    logic [5:0]   pred_offset;
    logic [14:0]  pred_ghr;
    logic         resolve_valid;
    logic         resolve_ready;
    logic         resolve_taken;
    logic         resolve_mispred;
    logic [11:0]  resolve_index;
    logic [5:0]   resolve_offset;
    logic [14:0]  resolve_ghr;
    logic [11:0]  bht_index;
    logic [127:0] bht_rdata;
    logic [11:0]  bht_index_in;
    logic [127:0] bht_dataout;
    logic         bht_write;
    logic [127:0] bht_datain;

    bit   [127:0] mem [4096];
    logic         preload_en;
    logic [11:0]  preload_idx;
    logic [127:0] preload_dat;
    int           wr_count = 0;
    logic [11:0]  wlog [$];

    int total = 0;
    int bad   = 0;
    int stall = 0;

    global_bht_update_ctrl #(
        .GHR_LEN    (15),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .predict_valid   (predict_valid),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_index      (pred_index),
        .pred_offset     (pred_offset),
        .pred_ghr        (pred_ghr),
        .resolve_valid   (resolve_valid),
        .resolve_ready   (resolve_ready),
        .resolve_taken   (resolve_taken),
        .resolve_mispred (resolve_mispred),
        .resolve_index   (resolve_index),
        .resolve_offset  (resolve_offset),
        .resolve_ghr     (resolve_ghr),
        .bht_index       (bht_index),
        .bht_rdata       (bht_rdata),
        .bht_index_in    (bht_index_in),
        .bht_dataout     (bht_dataout),
        .bht_write       (bht_write),
        .bht_datain      (bht_datain)
    );

    always #5 clk = ~clk;

    assign bht_rdata   = mem[bht_index];
    assign bht_dataout = mem[bht_index_in];

    always @(negedge clk) begin
        if (bht_write) begin
            mem[bht_index_in] <= bht_datain;
            wr_count <= wr_count + 1;
            wlog.push_back(bht_index_in);
        end else if (preload_en) begin
            mem[preload_idx] <= preload_dat;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] idx, input logic [5:0] off, input logic tk,
                        input logic mp, input logic [14:0] gh);
        int guard;
        guard           = 0;
        resolve_valid   = 1'b1;
        resolve_index   = idx;
        resolve_offset  = off;
        resolve_taken   = tk;
        resolve_mispred = mp;
        resolve_ghr     = gh;
        #1;
        while (!resolve_ready) begin
            stall++;
            guard++;
            if (guard > 50) begin
                total++;
                bad++;
                $error("FAIL resolve_ready_timeout: observed=0 expected=1 within 50 cycles");
                break;
            end
            tick();
        end
        tick();
        resolve_valid   = 1'b0;
        resolve_mispred = 1'b0;
    endtask

    initial begin
        int base;
        int wc0;
        logic [127:0] exp6;

        reset = 1'b1; predict_valid = 1'b0; fetch_pc = 16'h0000;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_mispred = 1'b0;
        resolve_index = '0; resolve_offset = '0; resolve_ghr = '0;
        preload_en = 1'b0; preload_idx = '0; preload_dat = '0;

        // Reset state
        #2;
        chk("rst_ready", resolve_ready, 1);
        chk("rst_write", bht_write, 0);
        chk("rst_index_in", bht_index_in, 0);
        chk("rst_datain", bht_datain, 0);
        chk("rst_ghr", pred_ghr, 0);
        #10 reset = 1'b0;
        tick();

        // 1: hash with ghr=0
        fetch_pc = 16'h0002;
        #1;
        chk("t1_index", pred_index, 12'h001);
        chk("t1_offset", pred_offset, 0);
        chk("t1_taken", pred_taken, 0);
        predict_valid = 1'b1;
        tick();
        predict_valid = 1'b0;
        chk("t1_ghr_shift0", pred_ghr, 15'h0000);

        // 2: counter walk 00->01->10->11, saturate, decrement
        send(12'h001, 6'd0, 1'b1, 1'b0, 15'h0);
        repeat (4) tick();
        chk("t2_ctr_01", mem[1], 128'h1);
        send(12'h001, 6'd0, 1'b1, 1'b0, 15'h0);
        repeat (4) tick();
        chk("t2_ctr_10", mem[1], 128'h2);
        send(12'h001, 6'd0, 1'b1, 1'b0, 15'h0);
        repeat (4) tick();
        chk("t2_ctr_11", mem[1], 128'h3);
        chk("t2_pred_taken", pred_taken, 1);
        send(12'h001, 6'd0, 1'b1, 1'b0, 15'h0);
        repeat (4) tick();
        chk("t2_sat_hi", mem[1], 128'h3);
        send(12'h001, 6'd0, 1'b0, 1'b0, 15'h0);
        repeat (4) tick();
        chk("t2_dec", mem[1], 128'h2);
        send(12'h002, 6'd1, 1'b0, 1'b0, 15'h0);
        repeat (4) tick();
        chk("t2_sat_lo", mem[2], 128'h0);
        predict_valid = 1'b1;
        tick();
        predict_valid = 1'b0;
        chk("t2_ghr_shift1", pred_ghr, 15'h0001);

        // 3: mispredict restore beats concurrent predict shift
        predict_valid = 1'b1;
        send(12'h100, 6'd5, 1'b1, 1'b1, 15'h1234);
        predict_valid = 1'b0;
        chk("t3_ghr_restore", pred_ghr, 15'h2469);
        #1;
        chk("t3_index", pred_index, 12'h468);
        chk("t3_offset", pred_offset, 6'd2);
        chk("t3_taken", pred_taken, 0);
        predict_valid = 1'b1;
        tick();
        predict_valid = 1'b0;
        chk("t3_ghr_shift", pred_ghr, 15'h48D2);
        repeat (4) tick();
        chk("t3_line", mem[12'h100], 128'h400);

        // 4: back-to-back resolves fill the buffer and stall
        base  = wlog.size();
        stall = 0;
        for (int i = 0; i < 7; i++) begin
            send(12'h010 + 12'(i), 6'(i), 1'b1, 1'b0, 15'h0);
        end
        chk("t4_stall_cycles", stall, 2);
        repeat (25) tick();
        chk("t4_write_count", wlog.size() - base, 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t4_order_%0d", i), wlog[base + i], 12'h010 + 12'(i));
            chk($sformatf("t4_line_%0d", i), mem[12'h010 + i], 128'h1 << (2 * i));
        end

        // 5: reset in READ abandons the update
        wc0 = wr_count;
        send(12'h200, 6'd0, 1'b1, 1'b0, 15'h0);
        tick();
        chk("t5_read_index", bht_index_in, 12'h200);
        chk("t5_read_nowrite", bht_write, 0);
        reset = 1'b1;
        #1;
        chk("t5_rst_index_in", bht_index_in, 0);
        chk("t5_rst_ready", resolve_ready, 1);
        chk("t5_rst_datain", bht_datain, 0);
        chk("t5_rst_ghr", pred_ghr, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (8) tick();
        chk("t5_no_write", wr_count, wc0);
        chk("t5_line_kept", mem[12'h200], 128'h0);
        chk("t5_idle_index", bht_index_in, 0);

        // 6: top counter of line 0xFFF; predict path sees old line during WRITE
        preload_idx = 12'hFFF;
        preload_dat = {64{2'b01}};
        preload_en  = 1'b1;
        tick();
        preload_en  = 1'b0;
        exp6        = {2'b10, {63{2'b01}}};
        fetch_pc    = 16'hE000;
        send(12'hFFF, 6'd63, 1'b1, 1'b1, 15'h3FFF);
        chk("t6_ghr", pred_ghr, 15'h7FFF);
        #1;
        chk("t6_index", pred_index, 12'hFFF);
        chk("t6_offset", pred_offset, 6'd63);
        chk("t6_taken_before", pred_taken, 0);
        tick();
        tick();
        chk("t6_write", bht_write, 1);
        chk("t6_write_index", bht_index_in, 12'hFFF);
        chk("t6_datain", bht_datain, exp6);
        chk("t6_stale_read", pred_taken, 0);
        tick();
        chk("t6_taken_after", pred_taken, 1);
        chk("t6_line", mem[12'hFFF], exp6);
        chk("t6_write_done", bht_write, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
